mem_cmd_arbiter: RTL and testbench
==================================

# mem_cmd_arbiter

Sits between the front-panel I/O controller and the SDRAM word controller, sharing the single memory port between two requesters: single-word user reads/writes and a clear engine that sweeps a programmed address range writing zeros. Owns the req/ack handshake to memory and generates the `mem_done` ready indication the I/O controller gates its state machine on. User commands preempt the sweep at word boundaries; the sweep then resumes where it stopped.

## Interface
- `ADDR_W`, 25, memory word-address width
- `DATA_W`, 16, memory data width
- `CLEAR_LAST`, 25'h1FF_FFFF, last address written by a clear sweep (sweep starts at 0)
- `TIMEOUT_CYCLES`, 1024, ack watchdog limit; used only with `MEM_ARB_TIMEOUT_EN`
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `io_req` in 1: user command strobe (level; a rising edge issues one command)
- `io_we` in 1: 1 = write, 0 = read; sampled on the `io_req` rising edge
- `io_addr` in `ADDR_W`: user address, sampled with `io_we`
- `io_wdata` in `DATA_W`: user write data, sampled with `io_we`
- `io_rdata` out `DATA_W`: last user read result
- `mem_done` out 1: high when idle with no pending work
- `clear_start` in 1: one-cycle pulse that starts a sweep
- `clear_busy` out 1: sweep in progress
- `mem_req` out 1: memory request, held until acked
- `mem_we` out 1, `mem_addr` out `ADDR_W`, `mem_wdata` out `DATA_W`: command fields, stable while `mem_req`=1
- `mem_ack` in 1: one-cycle completion pulse; `mem_rdata` valid in the same cycle
- `mem_rdata` in `DATA_W`: read data
- `timeout_err` out 1: sticky watchdog flag

## Operation
- States: IDLE, IO_REQ, CLR_REQ.
- The edge detector registers `io_req`. A rise latches `io_we/io_addr/io_wdata` into the pending user slot, which holds one command. A second rise while the slot is full is dropped.
- `clear_start` sets `clear_busy` and clears the sweep counter to 0. A pulse while `clear_busy`=1 is ignored.
- IDLE:
  - Pending user command → IO_REQ. User has priority.
  - Otherwise, `clear_busy` → CLR_REQ.
  - Otherwise, stay in IDLE.
- IO_REQ drives the latched command. On `mem_ack`:
  - For a read, `io_rdata` ← `mem_rdata`.
  - The slot is freed and the FSM returns to IDLE.
- CLR_REQ drives `mem_we`=1, `mem_addr`=sweep counter, `mem_wdata`=0. On `mem_ack`:
  - At `CLEAR_LAST`, `clear_busy` ← 0.
  - Otherwise, the counter increments.
  - Either way the FSM returns to IDLE, so a pending user command interleaves between sweep words.
- `mem_done` = (state==IDLE) & no pending user command & !`clear_busy`.
- `io_req` rise and `clear_start` in the same cycle: both are latched; the user command is issued first.
- Reset mid-operation: all state returns to reset values and `mem_req` drops the following edge. The in-flight memory op is abandoned, and the memory controller resets from the same `rst_n`.
- Reset values:
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `io_rdata`=0, `clear_busy`=0, `timeout_err`=0
  - `mem_done`=1, state=IDLE, user slot empty

## Timing
- `io_req` rise seen at edge N (registered previous value 0, current 1): `mem_req`=1 from edge N+1, provided IDLE with no in-flight op.
- `mem_ack` high at edge M:
  - `mem_req`=0 and `io_rdata` updated after edge M.
  - `mem_done`=1 after M if nothing is pending.
- Minimum one idle cycle between consecutive `mem_req` assertions.
- Clear sweep throughput is one word per (ack latency + 2) cycles.
- `clear_busy` falls the cycle after the ack for `CLEAR_LAST`.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs while `mem_req`=1.
  - Reaching `TIMEOUT_CYCLES` without `mem_ack` drops `mem_req`, sets `timeout_err`, returns to IDLE and frees the user slot (`io_rdata` unchanged) or aborts the sweep (`clear_busy` ← 0).
  - `timeout_err` clears on the next accepted `io_req` rise or `clear_start`.
- Undefined: no counter, waits indefinitely, `timeout_err` tied 0.

## Structure
- `mem_arb_pkg` contains the state enum `arb_state_t`, `ADDR_W`/`DATA_W` defaults, and the pending-command struct (`we`, `addr`, `wdata`).
- One sub-module, `clear_addr_gen`:
  - Sweep counter plus `clear_busy` flag.
  - Inputs: start and advance.
  - Outputs: address and last-flag.

## Test plan
- Write 16'hBEEF to 25'h0001234 via `io_req` rise, ack after 3 cycles → `mem_req` held 4 cycles with `mem_we`=1, `mem_addr`=25'h0001234, `mem_wdata`=16'hBEEF; `mem_done` returns to 1.
- Read 25'h0001234, `mem_rdata`=16'hBEEF on ack → `io_rdata`=16'hBEEF the cycle after ack.
- `CLEAR_LAST`=7, immediate acks → eight writes of 0 to addresses 0..7 in order; `clear_busy` falls after the ack for address 7.
- User write to 25'h40 arriving during the clear word at address 3 → order is clear 3, user 25'h40, clear 4; no address skipped or repeated.
- Same-cycle `io_req` rise and `clear_start` → user command issued first, then the sweep from address 0. `rst_n`=0 while `mem_req`=1 → all outputs at reset values after the next edge.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `mem_ack` never asserted → `mem_req` drops after 8 cycles and `timeout_err`=1 until the next `io_req` rise.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory command arbiter: FSM state encoding and the
// pending user command slot layout.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IO_REQ  = 2'd1,
    CLR_REQ = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } pend_cmd_t;

endpackage

// File: rtl/mem_cmd_arbiter_clear_addr_gen.sv
// Clear sweep address generator: counts from 0 up to CLEAR_LAST, one step per
// completed sweep word, and holds the busy flag for the duration of the sweep.
module clear_addr_gen
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] CLEAR_LAST = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              advance,
  input  logic              stop,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              busy
);

  logic [ADDR_W-1:0] addr_reg;
  logic              busy_reg;

  // A start pulse during an active sweep is ignored; the sweep keeps its place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg <= '0;
      busy_reg <= 1'b0;
    end else if (start && !busy_reg) begin
      addr_reg <= '0;
      busy_reg <= 1'b1;
    end else if (stop) begin
      busy_reg <= 1'b0;
    end else if (advance) begin
      addr_reg <= addr_reg + 1'b1;
    end
  end

  assign addr = addr_reg;
  assign last = (addr_reg == CLEAR_LAST);
  assign busy = busy_reg;

endmodule

// File: rtl/mem_cmd_arbiter.sv
// Shares one memory port between single-word user commands and a zero-fill
// sweep; optional ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_cmd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W         = DEF_ADDR_W,
  parameter int                DATA_W         = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] CLEAR_LAST     = '1,
  parameter int                TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_done,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  arb_state_t        state_reg, state_next;
  pend_cmd_t         pend_reg;
  logic              pend_valid_reg;
  logic              io_req_d_reg;
  logic [DATA_W-1:0] io_rdata_reg;
  logic              rise_accept, clear_accept, ack_io, ack_clr, tmo_fire;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_last, clr_busy, clr_advance, clr_stop;

  // A rise arriving while the slot is still occupied is dropped.
  assign rise_accept  = io_req & ~io_req_d_reg & ~pend_valid_reg;
  assign clear_accept = clear_start & ~clr_busy;
  assign ack_io       = (state_reg == IO_REQ) & mem_ack;
  assign ack_clr      = (state_reg == CLR_REQ) & mem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      io_req_d_reg   <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_reg       <= '0;
      io_rdata_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      io_req_d_reg <= io_req;
      if (rise_accept) begin
        pend_valid_reg <= 1'b1;
        pend_reg.we    <= io_we;
        pend_reg.addr  <= DEF_ADDR_W'(io_addr);
        pend_reg.wdata <= DEF_DATA_W'(io_wdata);
      end else if ((state_reg == IO_REQ) && (mem_ack || tmo_fire)) begin
        pend_valid_reg <= 1'b0;
      end
      if (ack_io && !pend_reg.we) io_rdata_reg <= mem_rdata;
    end
  end

  // Every request returns through IDLE, which gives the mandatory gap between
  // requests and lets a pending user command slip in between sweep words.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pend_valid_reg)  state_next = IO_REQ;
        else if (clr_busy)   state_next = CLR_REQ;
      end
      IO_REQ, CLR_REQ: begin
        if (mem_ack || tmo_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_reg)
      IO_REQ: begin
        mem_req   = 1'b1;
        mem_we    = pend_reg.we;
        mem_addr  = pend_reg.addr[ADDR_W-1:0];
        mem_wdata = pend_reg.wdata[DATA_W-1:0];
      end
      CLR_REQ: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_addr;
      end
      default: ;
    endcase
  end

  assign clr_advance = ack_clr & ~clr_last;
  assign clr_stop    = (ack_clr & clr_last) | ((state_reg == CLR_REQ) & tmo_fire);

  clear_addr_gen #(
    .ADDR_W     (ADDR_W),
    .CLEAR_LAST (CLEAR_LAST)
  ) u_clear_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (clear_start),
    .advance (clr_advance),
    .stop    (clr_stop),
    .addr    (clr_addr),
    .last    (clr_last),
    .busy    (clr_busy)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          timeout_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if ((state_reg == IDLE) || mem_ack) tmo_cnt_reg <= '0;
      else                                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      if (tmo_fire)                          timeout_err_reg <= 1'b1;
      else if (rise_accept || clear_accept)  timeout_err_reg <= 1'b0;
    end
  end

  // Fires on the last allowed cycle so mem_req is high exactly TIMEOUT_CYCLES cycles.
  assign tmo_fire    = (state_reg != IDLE) && !mem_ack && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_reg;
`else
  assign tmo_fire    = (TIMEOUT_CYCLES < 0) && clear_accept;
  assign timeout_err = 1'b0;
`endif

  assign mem_done   = (state_reg == IDLE) & ~pend_valid_reg & ~clr_busy;
  assign clear_busy = clr_busy;
  assign io_rdata   = io_rdata_reg;

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Directed bench for mem_cmd_arbiter with a behavioural memory responder;
// the watchdog case runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_cmd_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          io_req = 1'b0;
  logic          io_we = 1'b0;
  logic [AW-1:0] io_addr = '0;
  logic [DW-1:0] io_wdata = '0;
  logic [DW-1:0] io_rdata;
  logic          mem_done;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          timeout_err;

  int total = 0;
  int bad = 0;

  int            ack_delay = 0;
  bit            ack_en = 1'b1;
  int            ack_cnt = 0;
  int            run_len = 0;
  int            last_len = 0;
  logic [DW-1:0] rd_val = '0;
  logic [41:0]   log_q[$];
  logic [41:0]   exp_q[$];

  mem_cmd_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .CLEAR_LAST     (25'd7),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_req      (io_req),
    .io_we       (io_we),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .mem_done    (mem_done),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after ack_delay cycles of mem_req, logs each accepted op.
  always @(negedge clk) begin
    if (mem_req) run_len++;
    else begin
      if (run_len != 0) last_len = run_len;
      run_len = 0;
    end
    if (!rst_n) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_req && ack_en) begin
      if (ack_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_val;
        log_q.push_back({mem_we, mem_addr, mem_wdata});
        $display("txn we=%0b addr=%0h wdata=%0h", mem_we, mem_addr, mem_wdata);
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  function automatic logic [41:0] ent(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {we, a, d};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    io_we = we; io_addr = a; io_wdata = d; io_req = 1'b1;
    @(negedge clk);
    io_req = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!mem_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 64'(mem_done), 64'd1);
  endtask

  task automatic check_log(input string tag);
    check_val({tag, "_n"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check_val($sformatf("%s_%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check_val("rst_req",   64'(mem_req),    64'd0);
    check_val("rst_done",  64'(mem_done),   64'd1);
    check_val("rst_busy",  64'(clear_busy), 64'd0);
    check_val("rst_rdata", 64'(io_rdata),   64'd0);
    rst_n = 1'b1;

    // user write, ack after 3 cycles
    ack_delay = 3; rd_val = 16'hDEAD; log_q.delete();
    issue(1'b1, 25'h0001234, 16'hBEEF);
    check_val("t1_pre_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    check_val("t1_req",   64'(mem_req),  64'd1);
    check_val("t1_busy",  64'(mem_done), 64'd0);
    check_val("t1_we",    64'(mem_we),   64'd1);
    check_val("t1_addr",  64'(mem_addr), 64'h1234);
    check_val("t1_wdata", 64'(mem_wdata), 64'hBEEF);
    wait_idle("t1_done");
    @(negedge clk);
    check_val("t1_len", 64'(last_len), 64'd4);
    check_val("t1_rdata_kept", 64'(io_rdata), 64'd0);
    exp_q = '{ent(1'b1, 25'h1234, 16'hBEEF)};
    check_log("t1_log");

    // user read
    ack_delay = 1; rd_val = 16'hBEEF; log_q.delete();
    issue(1'b0, 25'h0001234, 16'h0);
    wait_idle("t2_done");
    check_val("t2_rdata", 64'(io_rdata), 64'hBEEF);
    exp_q = '{ent(1'b0, 25'h1234, 16'h0)};
    check_log("t2_log");

    // full sweep with immediate acks
    ack_delay = 0; log_q.delete();
    pulse_clear();
    check_val("t3_busy", 64'(clear_busy), 64'd1);
    check_val("t3_done", 64'(mem_done),   64'd0);
    wait_idle("t3_idle");
    check_val("t3_busy_end", 64'(clear_busy), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(1'b1, AW'(i), 16'h0));
    check_log("t3_log");

    // user write interleaved at sweep word 3
    ack_delay = 2; log_q.delete();
    pulse_clear();
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 25'd3) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check_val("t4_at3", 64'(mem_addr), 64'd3);
    end
    issue(1'b1, 25'h40, 16'h1111);
    wait_idle("t4_done");
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(1'b1, AW'(i), 16'h0));
    exp_q.push_back(ent(1'b1, 25'h40, 16'h1111));
    for (int i = 4; i < 8; i++) exp_q.push_back(ent(1'b1, AW'(i), 16'h0));
    check_log("t4_log");

    // same-cycle user rise and clear start
    ack_delay = 0; log_q.delete();
    @(negedge clk);
    io_we = 1'b1; io_addr = 25'h55; io_wdata = 16'hA5A5; io_req = 1'b1; clear_start = 1'b1;
    @(negedge clk);
    io_req = 1'b0; clear_start = 1'b0;
    wait_idle("t5_done");
    exp_q = '{ent(1'b1, 25'h55, 16'hA5A5)};
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(1'b1, AW'(i), 16'h0));
    check_log("t5_log");

    // reset while a request is outstanding
    ack_en = 1'b0;
    issue(1'b1, 25'h77, 16'h7777);
    @(negedge clk);
    check_val("t6_req_pre", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("t6_req",   64'(mem_req),     64'd0);
    check_val("t6_we",    64'(mem_we),      64'd0);
    check_val("t6_addr",  64'(mem_addr),    64'd0);
    check_val("t6_wdata", 64'(mem_wdata),   64'd0);
    check_val("t6_rdata", 64'(io_rdata),    64'd0);
    check_val("t6_busy",  64'(clear_busy),  64'd0);
    check_val("t6_terr",  64'(timeout_err), 64'd0);
    check_val("t6_done",  64'(mem_done),    64'd1);
    rst_n = 1'b1;
    ack_en = 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog: no ack ever arrives
    ack_en = 1'b0;
    issue(1'b1, 25'h99, 16'h9999);
    wait_idle("t7_done");
    @(negedge clk);
    check_val("t7_len",  64'(last_len),    64'd8);
    check_val("t7_terr", 64'(timeout_err), 64'd1);
    repeat (3) @(negedge clk);
    check_val("t7_terr_hold", 64'(timeout_err), 64'd1);
    ack_en = 1'b1; ack_delay = 0;
    issue(1'b0, 25'h99, 16'h0);
    check_val("t7_terr_clr", 64'(timeout_err), 64'd0);
    wait_idle("t7_done2");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
